// File: rtl/project1_seq.sv
// Operand sequencer: collects up to four {A,B} pairs on load-strobe rises and
// issues them in order over a valid/ready port when the start strobe rises.
module project1_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] partA,
  input  logic [3:0] partB,
  input  logic       partC,
  input  logic       partD,
  input  logic       dp_ready,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  output logic       dp_valid,
  output logic [2:0] count,
  output logic       full,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [7:0] buffer [4];
  logic [1:0] idx;
  logic       cprev;
  logic       dprev;
  logic       cRise;
  logic       dRise;
  logic       loadOk;
  logic [2:0] countLoaded;
  logic       lastIssue;

  assign cRise  = partC & ~cprev;
  assign dRise  = partD & ~dprev;
  assign loadOk = (state == IDLE) && cRise && (count < 3'd4);

  // A load on the same edge as a start counts toward the run being launched.
  assign countLoaded = loadOk ? count + 3'd1 : count;
  assign lastIssue   = ({1'b0, idx} == count - 3'd1);

  assign full = (count == 3'd4);

  // Handshake: a pair transfers on any rising edge where dp_valid and dp_ready
  // are both high; dp_a/dp_b stay constant while dp_valid waits for dp_ready.
  always_comb begin
    stateNext = state;
    dp_valid  = 1'b0;
    dp_a      = 4'd0;
    dp_b      = 4'd0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (dRise && (countLoaded != 3'd0)) stateNext = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        dp_valid = 1'b1;
        dp_a     = buffer[idx][7:4];
        dp_b     = buffer[idx][3:0];
        if (dp_ready && lastIssue) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 3'd0;
      idx   <= 2'd0;
      ovf   <= 1'b0;
      cprev <= 1'b0;
      dprev <= 1'b0;
    end else begin
      state <= stateNext;
      cprev <= partC;
      dprev <= partD;
      case (state)
        IDLE: begin
          if (loadOk) begin
            buffer[count[1:0]] <= {partA, partB};
            count              <= count + 3'd1;
          end else if (cRise) begin
            ovf <= 1'b1;
          end
          if (stateNext == RUN) idx <= 2'd0;
        end
        RUN: begin
          if (dp_ready && !lastIssue) idx <= idx + 2'd1;
        end
        DONE: begin
          // Contents are left in place; only the occupancy is cleared.
          count <= 3'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_project1_seq.sv
// Bench for project1_seq: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_project1_seq;

  logic       clk;
  logic       rst;
  logic [3:0] partA;
  logic [3:0] partB;
  logic       partC;
  logic       partD;
  logic       dp_ready;
  logic [3:0] dp_a;
  logic [3:0] dp_b;
  logic       dp_valid;
  logic [2:0] count;
  logic       full;
  logic       busy;
  logic       done;
  logic       ovf;

  project1_seq dut (
    .clk      (clk),
    .rst      (rst),
    .partA    (partA),
    .partB    (partB),
    .partC    (partC),
    .partD    (partD),
    .dp_ready (dp_ready),
    .dp_a     (dp_a),
    .dp_b     (dp_b),
    .dp_valid (dp_valid),
    .count    (count),
    .full     (full),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the buffered pairs in arrival order; mMode: 0 waiting,
  // 1 issuing exp_q[mPos], 2 finishing pulse.
  logic [7:0] exp_q[$];
  int         mMode = 0;
  int         mPos  = 0;
  bit         mOvf  = 0;
  bit         mC    = 0;
  bit         mD    = 0;
  bit         live  = 0;

  always @(posedge clk) begin : model
    bit cr, dr;
    if (rst) begin
      exp_q.delete();
      mMode = 0; mPos = 0; mOvf = 0; mC = 0; mD = 0;
      live  = 1;
    end else if (live) begin
      cr = partC && !mC;
      dr = partD && !mD;
      if (mMode == 0) begin
        if (cr) begin
          if (exp_q.size() < 4) exp_q.push_back({partA, partB});
          else mOvf = 1;
        end
        if (dr && exp_q.size() > 0) begin
          mMode = 1; mPos = 0;
        end
      end else if (mMode == 1) begin
        if (dp_ready) begin
          if (mPos == exp_q.size() - 1) mMode = 2;
          else mPos++;
        end
      end else begin
        exp_q.delete();
        mMode = 0;
      end
      mC = partC;
      mD = partD;
    end
  end

  // ---------------- per-cycle compare and monitor ----------------
  logic [7:0] iss_q[$];
  int         vcyc     = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin : cmp
    logic [15:0] e, a;
    logic [7:0]  cur;
    logic [31:0] sz;
    if (live) begin
      sz  = exp_q.size();
      cur = 8'h00;
      if (mMode == 1) cur = exp_q[mPos];
      e = {mMode == 1, cur, sz[2:0], sz == 4, mMode == 1, mMode == 2, mOvf};
      a = {dp_valid, dp_a, dp_b, count, full, busy, done, ovf};
      chk("cycle {valid,a,b,count,full,busy,done,ovf}", {16'h0, a}, {16'h0, e});
      if (dp_valid && dp_ready) iss_q.push_back({dp_a, dp_b});
      if (dp_valid) vcyc++;
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input int hold);
    partA = a;
    partB = b;
    partC = 1'b1;
    tick(hold);
    partC = 1'b0;
    tick(1);
  endtask

  task automatic start();
    partD = 1'b1;
    tick(1);
    partD = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick(1);
      n++;
    end
    chk("wait_done timeout", n < budget, 1);
  endtask

  task automatic chk_issued(input string nm, input logic [7:0] lit[4], input int n);
    chk({nm, " issued count"}, iss_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < iss_q.size()) chk({nm, " issued pair"}, iss_q[i], lit[i]);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] lit[4];

  initial begin
    rst = 1'b1; partA = 0; partB = 0; partC = 0; partD = 0; dp_ready = 0;
    tick(2);
    rst = 1'b0;

    // reset state
    chk("reset count", count, 0);
    chk("reset dp_valid", dp_valid, 0);
    chk("reset ovf", ovf, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);

    // four held loads then a full-throughput run
    load(4'h1, 4'hA, 5); load(4'h2, 4'h5, 5); load(4'h4, 4'hE, 5); load(4'h8, 4'h6, 5);
    chk("four loads count", count, 4);
    chk("four loads full", full, 1);
    chk("four loads ovf", ovf, 0);
    iss_q.delete(); done_cnt = 0; vcyc = 0;
    dp_ready = 1'b1;
    start();
    wait_done(20);
    tick(1);
    lit = '{8'h1A, 8'h25, 8'h4E, 8'h86};
    chk_issued("basic run", lit, 4);
    chk("basic run valid cycles", vcyc, 4);
    chk("basic run done pulses", done_cnt, 1);
    chk("basic run count after", count, 0);

    // fifth load is dropped and flagged
    load(4'h3, 4'hC, 1); load(4'h7, 4'h1, 1); load(4'h0, 4'hF, 1); load(4'hE, 4'h2, 1);
    load(4'hF, 4'hF, 2);
    chk("overflow count", count, 4);
    chk("overflow ovf", ovf, 1);
    iss_q.delete();
    start();
    wait_done(20);
    tick(1);
    lit = '{8'h3C, 8'h71, 8'h0F, 8'hE2};
    chk_issued("overflow run", lit, 4);
    chk("overflow sticky", ovf, 1);

    // reset in the middle of a three-pair run
    load(4'h1, 4'h1, 1); load(4'h2, 4'h2, 1); load(4'h3, 4'h3, 1);
    start();
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    done_cnt = 0;
    chk("mid-run reset dp_valid", dp_valid, 0);
    chk("mid-run reset count", count, 0);
    chk("mid-run reset ovf", ovf, 0);
    tick(3);
    chk("mid-run reset no done", done_cnt, 0);
    iss_q.delete();
    load(4'h5, 4'h9, 1);
    start();
    wait_done(20);
    tick(1);
    chk("after reset run size", iss_q.size(), 1);
    if (iss_q.size() > 0) chk("after reset run pair", iss_q[0], 8'h59);

    // backpressure: first pair held four cycles
    do_reset();
    load(4'h1, 4'h2, 1); load(4'h3, 4'h4, 1);
    dp_ready = 1'b0;
    iss_q.delete(); vcyc = 0;
    start();
    tick(3);
    dp_ready = 1'b1;
    wait_done(20);
    tick(1);
    lit = '{8'h12, 8'h34, 8'h00, 8'h00};
    chk_issued("backpressure", lit, 2);
    chk("backpressure valid cycles", vcyc, 5);

    // start with an empty buffer
    done_cnt = 0;
    start();
    chk("empty start busy", busy, 0);
    chk("empty start dp_valid", dp_valid, 0);
    chk("empty start done", done, 0);
    tick(2);
    chk("empty start done pulses", done_cnt, 0);

    // load and start on the same edge
    load(4'h7, 4'h7, 1);
    chk("same-edge pre count", count, 1);
    partA = 4'h9; partB = 4'h9; partC = 1'b1; partD = 1'b1;
    tick(1);
    partC = 1'b0; partD = 1'b0;
    iss_q.delete();
    wait_done(20);
    tick(1);
    lit = '{8'h77, 8'h99, 8'h00, 8'h00};
    chk_issued("same-edge", lit, 2);

    // randomized soak against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      partA    = 4'($urandom_range(0, 15));
      partB    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) partC = ~partC;
      if ($urandom_range(0, 5) == 0) partD = ~partD;
      dp_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
